// File: rtl/rr_arbiter_8_pkg.sv
// rtl/rr_arbiter_8_pkg.sv - shared types, constants and round-robin search for rr_arbiter_8
package rr_arbiter_8_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Picks the first set request strictly after ptr, wrapping; ptr itself is checked last.
    // Iterating from the farthest offset down lets the nearest hit overwrite the result.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] idx;
        pick = ptr;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = ptr + k[IDX_W-1:0];
            if (req[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter_8_dec3to8.sv
// rtl/rr_arbiter_8_dec3to8.sv - 3-to-8 one-hot decoder with enable
module dec3to8 (
    input  logic [2:0] sel,
    input  logic       en,
    output logic [7:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// rtl/rr_arbiter_8.sv - 8-way round-robin arbiter with bounded hold and forced revoke
module rr_arbiter_8
    import rr_arbiter_8_pkg::*;
#(
    parameter int MAX_HOLD = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [IDX_W-1:0]   gnt_id,
    output logic               timeout
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  ptr, ptr_nxt;
    logic [IDX_W-1:0]  id_nxt;
    logic [IDX_W-1:0]  pick;
    logic [HOLD_W-1:0] hold, hold_nxt;
    logic              hold_last;
    logic              to_nxt;

    assign pick      = rr_pick(req, ptr);
    // hold counts completed GRANT cycles; the current one is the last allowed
    assign hold_last = (hold == HOLD_W'(MAX_HOLD - 1));
    assign gnt_valid = (state == GRANT);

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        id_nxt    = gnt_id;
        hold_nxt  = hold;
        to_nxt    = 1'b0;
        case (state)
            IDLE: begin
                hold_nxt = '0;
                id_nxt   = '0;
                if (|req) begin
                    state_nxt = GRANT;
                    id_nxt    = pick;
                    ptr_nxt   = pick;
                end
            end
            GRANT: begin
                hold_nxt = hold + 1'b1;
                if (!req[gnt_id]) begin
                    state_nxt = IDLE;
                    id_nxt    = '0;
                end else if (hold_last) begin
                    state_nxt = IDLE;
                    id_nxt    = '0;
                    to_nxt    = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                id_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= 3'd7;
            hold    <= '0;
            gnt_id  <= '0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            hold    <= hold_nxt;
            gnt_id  <= id_nxt;
            timeout <= to_nxt;
        end
    end

    dec3to8 u_dec (
        .sel (gnt_id),
        .en  (gnt_valid),
        .y   (gnt)
    );

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb/tb_rr_arbiter_8.sv - self-checking bench for rr_arbiter_8 (MAX_HOLD 15 and 4 instances)
module tb_rr_arbiter_8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;

    logic [7:0] gnt_a, gnt_b;
    logic       gv_a, gv_b;
    logic [2:0] id_a, id_b;
    logic       to_a, to_b;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    rr_arbiter_8 #(.MAX_HOLD(15)) dut_a (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt_a), .gnt_valid(gv_a), .gnt_id(id_a), .timeout(to_a)
    );

    rr_arbiter_8 #(.MAX_HOLD(4)) dut_b (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt_b), .gnt_valid(gv_b), .gnt_id(id_b), .timeout(to_b)
    );

    always #5 clk = ~clk;

    // Reference model: owner index (-1 = none), last granted index, cycles held
    int m_owner [2];
    int m_ptr   [2];
    int m_hold  [2];
    bit m_to    [2];
    int m_wait  [2][8];

    function automatic int max_hold(input int k);
        return (k == 0) ? 15 : 4;
    endfunction

    task automatic model_step(input int k);
        int idx;
        if (rst) begin
            m_owner[k] = -1;
            m_ptr[k]   = 7;
            m_hold[k]  = 0;
            m_to[k]    = 1'b0;
            for (int i = 0; i < 8; i++) m_wait[k][i] = 0;
        end else begin
            for (int i = 0; i < 8; i++) if (!req[i]) m_wait[k][i] = 0;
            m_to[k] = 1'b0;
            if (m_owner[k] < 0) begin
                if (req != 8'h00) begin
                    idx = -1;
                    for (int s = 1; s <= 8; s++)
                        if (idx < 0 && req[(m_ptr[k] + s) % 8]) idx = (m_ptr[k] + s) % 8;
                    for (int i = 0; i < 8; i++)
                        if (req[i] && i != idx) m_wait[k][i]++;
                    m_wait[k][idx] = 0;
                    m_owner[k] = idx;
                    m_ptr[k]   = idx;
                    m_hold[k]  = 0;
                end
            end else begin
                m_hold[k]++;
                if (!req[m_owner[k]]) begin
                    m_owner[k] = -1;
                end else if (m_hold[k] >= max_hold(k)) begin
                    m_owner[k] = -1;
                    m_to[k]    = 1'b1;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    task automatic check(input bit ok, input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input int k, input logic [7:0] g, input logic v, input logic [2:0] id, input logic to);
        logic [7:0] e;
        logic [7:0] dec;
        int         worst;
        e = 8'h00;
        if (m_owner[k] >= 0) e[m_owner[k]] = 1'b1;
        dec = v ? (8'd1 << id) : 8'd0;
        worst = 0;
        for (int i = 0; i < 8; i++) if (m_wait[k][i] > worst) worst = m_wait[k][i];
        check(g === e, $sformatf("gnt_dut%0d", k), g, e);
        check(v === (m_owner[k] >= 0), $sformatf("valid_dut%0d", k), {7'b0, v}, {7'b0, m_owner[k] >= 0});
        check(id === ((m_owner[k] >= 0) ? 3'(m_owner[k]) : 3'd0), $sformatf("id_dut%0d", k),
              {5'b0, id}, (m_owner[k] >= 0) ? 8'(m_owner[k]) : 8'd0);
        check(to === m_to[k], $sformatf("timeout_dut%0d", k), {7'b0, to}, {7'b0, m_to[k]});
        check($countones(g) <= 1, $sformatf("onehot_dut%0d", k), g, e);
        check(g === dec, $sformatf("decode_dut%0d", k), g, dec);
        check(worst <= 7, $sformatf("starve_dut%0d", k), 8'(worst), 8'd7);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp(0, gnt_a, gv_a, id_a, to_a);
            cmp(1, gnt_b, gv_b, id_b, to_b);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 8'h00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req = 8'h00;
        tick();
        tick();
        chk_en = 1'b1;
        check(gnt_a === 8'h00, "rst_gnt_a", gnt_a, 8'h00);
        check(gv_a === 1'b0, "rst_valid_a", {7'b0, gv_a}, 8'h00);
        check(id_a === 3'd0, "rst_id_a", {5'b0, id_a}, 8'h00);
        check(to_a === 1'b0, "rst_timeout_a", {7'b0, to_a}, 8'h00);
        check(gnt_b === 8'h00, "rst_gnt_b", gnt_b, 8'h00);
        rst = 1'b0;

        // single requester: one-cycle latency, drop releases next cycle
        req = 8'h01;
        tick();
        check(gnt_a === 8'h01, "single_grant", gnt_a, 8'h01);
        req = 8'h00;
        tick();
        check(gnt_a === 8'h00, "single_drop", gnt_a, 8'h00);

        // all requesting, each owner leaves after two cycles
        do_reset();
        req = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            tick();
            check(gnt_a === (8'd1 << (g % 8)), "rr_order_c1", gnt_a, 8'd1 << (g % 8));
            tick();
            check(gnt_a === (8'd1 << (g % 8)), "rr_order_c2", gnt_a, 8'd1 << (g % 8));
            req = 8'hFF & ~(8'd1 << (g % 8));
            tick();
            check(gnt_a === 8'h00, "rr_idle_gap", gnt_a, 8'h00);
            req = 8'hFF;
        end
        req = 8'h00;
        tick();

        // forced revoke with a lone requester, then re-grant to the same one
        do_reset();
        req = 8'h08;
        for (int c = 0; c < 4; c++) begin
            tick();
            check(gnt_b === 8'h08, "hold_grant", gnt_b, 8'h08);
            check(to_b === 1'b0, "hold_no_timeout", {7'b0, to_b}, 8'h00);
        end
        tick();
        check(gnt_b === 8'h00, "revoke_gnt", gnt_b, 8'h00);
        check(to_b === 1'b1, "revoke_timeout", {7'b0, to_b}, 8'h01);
        tick();
        check(gnt_b === 8'h08, "regrant_same", gnt_b, 8'h08);
        check(to_b === 1'b0, "regrant_timeout_low", {7'b0, to_b}, 8'h00);
        req = 8'h00;
        tick();
        tick();

        // forced revoke with a competitor: the other requester wins next
        do_reset();
        req = 8'h88;
        for (int c = 0; c < 4; c++) begin
            tick();
            check(gnt_b === 8'h08, "compete_hold", gnt_b, 8'h08);
        end
        tick();
        check(gnt_b === 8'h00, "compete_revoke", gnt_b, 8'h00);
        check(to_b === 1'b1, "compete_timeout", {7'b0, to_b}, 8'h01);
        tick();
        check(gnt_b === 8'h80, "compete_next", gnt_b, 8'h80);
        req = 8'h00;
        tick();
        tick();

        // reset in the middle of a grant
        do_reset();
        req = 8'h20;
        tick();
        check(gnt_a === 8'h20, "pre_rst_grant", gnt_a, 8'h20);
        rst = 1'b1;
        tick();
        check(gnt_a === 8'h00, "mid_rst_gnt", gnt_a, 8'h00);
        check(gv_a === 1'b0, "mid_rst_valid", {7'b0, gv_a}, 8'h00);
        rst = 1'b0;
        req = 8'h21;
        tick();
        check(gnt_a === 8'h01, "post_rst_from0", gnt_a, 8'h01);

        // wrap-around from ptr = 5 and from ptr = 6
        req = 8'h20;
        tick();
        tick();
        check(gnt_a === 8'h20, "wrap_setup", gnt_a, 8'h20);
        req = 8'h00;
        tick();
        req = 8'h41;
        tick();
        check(gnt_a === 8'h40, "wrap_ptr5", gnt_a, 8'h40);
        req = 8'h01;
        tick();
        check(gnt_a === 8'h00, "wrap_gap", gnt_a, 8'h00);
        tick();
        check(gnt_a === 8'h01, "wrap_ptr6", gnt_a, 8'h01);
        req = 8'h00;
        tick();
        tick();

        // sparse random toggling, checked against the model every cycle
        for (int n = 0; n < 10000; n++) begin
            req = req ^ 8'($urandom & $urandom & $urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
